st7735_spi_receiver: RTL and testbench
======================================

ST7735_SPI_RECEIVER -- requirements
Module: st7735_spi_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each serial input (legal 2..3).
REQ-002 Parameter PARAM_MAX, default 31, saturation value of PARAM_INDEX.
REQ-003 SYSTEM_CLK  input  1  sole clock; all state on rising edge.
REQ-004 RESET_N  input  1  synchronous, active-low reset.
REQ-005 CS  input  1  panel chip select, active low, asynchronous to SYSTEM_CLK.
REQ-006 LCD_CLK  input  1  serial clock, idles high, asynchronous; data sampled on its rising edge.
REQ-007 MOSI  input  1  serial data, MSB first.
REQ-008 DC  input  1  0 = command byte, 1 = parameter/data byte.
REQ-009 BYTE_DATA  output  8  last completed byte, held until the next byte completes.
REQ-010 BYTE_VALID  output  1  one-cycle pulse per completed byte.
REQ-011 BYTE_IS_CMD  output  1  DC value latched with BYTE_DATA.
REQ-012 CMD_REG  output  8  last received command byte.
REQ-013 PARAM_INDEX  output  5  count of data bytes since the last command.
REQ-014 BUSY  output  1  high while CS asserted and a byte is partially shifted.
REQ-015 FRAME_ERR  output  1  one-cycle pulse when CS deasserts mid-byte.
REQ-016 PARAM_ERR  output  1  sticky; too many parameters for a known command (see Configuration).

Function
REQ-017 CS, LCD_CLK, MOSI, DC each SHALL pass through SYNC_STAGES flops plus one history flop; edges are detected on the synchronized copies only.
REQ-018 Legal LCD_CLK: high and low phases each >= 2 SYSTEM_CLK periods; faster input is unsupported, no detection required.
REQ-019 FSM states IDLE, SHIFT, HOLD. IDLE -> SHIFT on synchronized CS low; SHIFT -> HOLD when a byte completes; HOLD -> SHIFT next cycle if CS still low, else IDLE; any state -> IDLE on synchronized CS high.
REQ-020 In SHIFT, each detected LCD_CLK rising edge SHALL shift synchronized MOSI into an 8-bit shift register LSB side and increment a 3-bit bit counter.
REQ-021 On the 8th edge the byte and synchronized DC SHALL be captured; BYTE_DATA, BYTE_IS_CMD update and BYTE_VALID goes high on the same SYSTEM_CLK edge (SYNC_STAGES+1 edges after LCD_CLK first sampled high), for exactly one cycle.
REQ-022 Bit counter wraps 7 -> 0 on byte completion; back-to-back bytes without CS release SHALL be received with no lost bits.
REQ-023 Command byte: CMD_REG <= byte, PARAM_INDEX <= 0, same edge as BYTE_VALID.
REQ-024 Data byte: PARAM_INDEX <= PARAM_INDEX + 1, saturating at PARAM_MAX; CMD_REG unchanged.
REQ-025 Data byte before any command since reset: delivered normally with CMD_REG = 0x00.
REQ-026 Synchronized CS rising while bit counter != 0: partial byte discarded, no BYTE_VALID, FRAME_ERR pulses one cycle, bit counter <= 0.
REQ-027 CS rising in the same cycle as the 8th edge: byte completes normally, no FRAME_ERR.
REQ-028 LCD_CLK edges while CS high SHALL be ignored.
REQ-029 BUSY = (state == SHIFT) and bit counter != 0.

Reset
REQ-030 RESET_N low at a SYSTEM_CLK edge: state IDLE, shift register, bit counter, BYTE_DATA, CMD_REG, PARAM_INDEX = 0; BYTE_VALID, BYTE_IS_CMD, BUSY, FRAME_ERR, PARAM_ERR = 0; synchronizers load CS=1, LCD_CLK=1, MOSI=0, DC=0.
REQ-031 Reset mid-byte SHALL discard the partial byte with no BYTE_VALID or FRAME_ERR; reception resumes at the next CS falling edge after release.

Configuration
REQ-032 Macro ST7735_RX_PARAM_CHECK_EN defined: expected parameter counts 0x11:0, B1:3, B2:3, B3:6, B4:1, C0:3, C1:1, C2:2, C3:2, C4:2, C5:1, E0:16, E1:16; a data byte making PARAM_INDEX exceed the count for CMD_REG sets PARAM_ERR, cleared only by reset; other commands unchecked.
REQ-033 Macro undefined: no check logic; PARAM_ERR tied to 0.

Verification
REQ-034 Reset, CS low, send 0x11 with DC=0 at LCD_CLK = SYSTEM_CLK/4 -> one BYTE_VALID, BYTE_DATA=0x11, BYTE_IS_CMD=1, CMD_REG=0x11, PARAM_INDEX=0.
REQ-035 One CS window: 0xB1 (DC=0), 0x01, 0x2C, 0x2D (DC=1) -> four BYTE_VALID pulses, PARAM_INDEX 0,1,2,3, CMD_REG stays 0xB1, FRAME_ERR never high.
REQ-036 Send 5 bits then raise CS -> FRAME_ERR one pulse, no BYTE_VALID; next full byte 0xC0 received correctly.
REQ-037 Macro defined: 0xC1 then data 0x05, 0x06 -> PARAM_ERR set on 2nd data byte and stays set; macro undefined -> PARAM_ERR stays 0.
REQ-038 RESET_N low after 4 bits, release, send 0x3A -> no output from partial byte; BYTE_DATA=0x3A, all other outputs at reset values beforehand.

Source files
------------

// File: rtl/st7735_spi_receiver.sv
// st7735_spi_receiver
// Slave-side receiver for the ST7735 panel's 4-wire serial interface
// (CS, LCD_CLK, MOSI, DC), oversampled by SYSTEM_CLK. Every serial input
// goes through a SYNC_STAGES-deep synchronizer followed by one history flop.
// Edges are detected only on the synchronized copies. Completed bytes come
// out as one-cycle BYTE_VALID pulses. The current command and the parameter
// index that follows it are tracked.
// Optional feature: define ST7735_RX_PARAM_CHECK_EN to flag parameter
// overruns on known commands through the sticky PARAM_ERR output.
// Without the macro, PARAM_ERR is tied to 0.

module st7735_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int PARAM_MAX   = 31
) (
  input  logic       SYSTEM_CLK,
  input  logic       RESET_N,
  input  logic       CS,
  input  logic       LCD_CLK,
  input  logic       MOSI,
  input  logic       DC,
  output logic [7:0] BYTE_DATA,
  output logic       BYTE_VALID,
  output logic       BYTE_IS_CMD,
  output logic [7:0] CMD_REG,
  output logic [4:0] PARAM_INDEX,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       PARAM_ERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [4:0] PIDX_MAX = 5'(PARAM_MAX);

  // Synchronizer chains plus one history flop per serial input
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
  logic cs_hist_q, cs_hist_d, clk_hist_q, clk_hist_d;
  logic mosi_hist_q, mosi_hist_d, dc_hist_q, dc_hist_d;

  // Receiver state
  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_is_cmd_q, byte_is_cmd_d;
  logic [7:0] cmd_reg_q, cmd_reg_d;
  logic [4:0] pidx_q, pidx_d;
  logic       frame_err_q, frame_err_d;

  logic       cs_s, clk_s, clk_rise, cs_rise;
  logic       byte_done;
  logic [4:0] pidx_inc;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;

  // Advance the synchronizer chains and capture the history copies
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], LCD_CLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], DC};
    cs_hist_d   = cs_s;
    clk_hist_d  = clk_s;
    mosi_hist_d = mosi_sync_q[SYNC_STAGES-1];
    dc_hist_d   = dc_sync_q[SYNC_STAGES-1];
  end

  // Next-state logic: shift bits in, complete bytes, handle CS release
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    byte_is_cmd_d = byte_is_cmd_q;
    cmd_reg_d     = cmd_reg_q;
    pidx_d        = pidx_q;
    frame_err_d   = 1'b0;
    byte_done     = 1'b0;
    pidx_inc      = (pidx_q < PIDX_MAX) ? pidx_q + 5'd1 : pidx_q;

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_rise) begin
          shift_d   = {shift_q[6:0], mosi_hist_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: state_d = ST_SHIFT;
      default: state_d = ST_IDLE;
    endcase

    if (byte_done) begin
      byte_data_d   = {shift_q[6:0], mosi_hist_q};
      byte_valid_d  = 1'b1;
      byte_is_cmd_d = ~dc_hist_q;
      if (!dc_hist_q) begin
        cmd_reg_d = byte_data_d;
        pidx_d    = 5'd0;
      end else begin
        pidx_d = pidx_inc;
      end
    end

    // A byte that completes in the same cycle as CS release is kept.
    // Any other partial byte is dropped and flagged.
    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      if (cs_rise && (bit_cnt_q != 3'd0) && !byte_done) frame_err_d = 1'b1;
    end
  end

  // Register all state; synchronous active-low reset
  always_ff @(posedge SYSTEM_CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    if (!RESET_N) begin
      // NOTE: the synchronizers reset to the bus idle levels (CS and LCD_CLK
      // high), so leaving reset creates no false edges.
      cs_sync_q     <= '1;
      clk_sync_q    <= '1;
      mosi_sync_q   <= '0;
      dc_sync_q     <= '0;
      cs_hist_q     <= 1'b1;
      clk_hist_q    <= 1'b1;
      mosi_hist_q   <= 1'b0;
      dc_hist_q     <= 1'b0;
      state_q       <= ST_IDLE;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_data_q   <= 8'h00;
      byte_valid_q  <= 1'b0;
      byte_is_cmd_q <= 1'b0;
      cmd_reg_q     <= 8'h00;
      pidx_q        <= 5'd0;
      frame_err_q   <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      clk_sync_q    <= clk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      dc_sync_q     <= dc_sync_d;
      cs_hist_q     <= cs_hist_d;
      clk_hist_q    <= clk_hist_d;
      mosi_hist_q   <= mosi_hist_d;
      dc_hist_q     <= dc_hist_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      byte_is_cmd_q <= byte_is_cmd_d;
      cmd_reg_q     <= cmd_reg_d;
      pidx_q        <= pidx_d;
      frame_err_q   <= frame_err_d;
    end
  end

`ifdef ST7735_RX_PARAM_CHECK_EN
  logic       param_err_q, param_err_d;
  logic [5:0] limit;

  // Expected parameter count per command as {known, count}
  function automatic logic [5:0] param_limit(input logic [7:0] cmd);
    case (cmd)
      8'h11:   return {1'b1, 5'd0};
      8'hB1:   return {1'b1, 5'd3};
      8'hB2:   return {1'b1, 5'd3};
      8'hB3:   return {1'b1, 5'd6};
      8'hB4:   return {1'b1, 5'd1};
      8'hC0:   return {1'b1, 5'd3};
      8'hC1:   return {1'b1, 5'd1};
      8'hC2:   return {1'b1, 5'd2};
      8'hC3:   return {1'b1, 5'd2};
      8'hC4:   return {1'b1, 5'd2};
      8'hC5:   return {1'b1, 5'd1};
      8'hE0:   return {1'b1, 5'd16};
      8'hE1:   return {1'b1, 5'd16};
      default: return 6'd0;
    endcase
  endfunction

  // Set the sticky error when a data byte exceeds the known parameter count
  always_comb begin
    param_err_d = param_err_q;
    limit       = param_limit(cmd_reg_q);
    if (byte_done && dc_hist_q && limit[5] && (pidx_inc > limit[4:0]))
      param_err_d = 1'b1;
  end

  // Sticky error flop, cleared only by reset
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) param_err_q <= 1'b0;
    else          param_err_q <= param_err_d;
  end

  assign PARAM_ERR = param_err_q;
`else
  assign PARAM_ERR = 1'b0;
`endif

  assign BYTE_DATA   = byte_data_q;
  assign BYTE_VALID  = byte_valid_q;
  assign BYTE_IS_CMD = byte_is_cmd_q;
  assign CMD_REG     = cmd_reg_q;
  assign PARAM_INDEX = pidx_q;
  assign FRAME_ERR   = frame_err_q;
  assign BUSY        = (state_q == ST_SHIFT) && (bit_cnt_q != 3'd0);

endmodule

// File: tb/tb_st7735_spi_receiver.sv
// tb_st7735_spi_receiver
// Directed and random serial transactions drive st7735_spi_receiver. A
// byte-level reference model predicts each received byte, the CMD_REG and
// PARAM_INDEX seen with it, PARAM_ERR, and the exact cycle of each
// BYTE_VALID pulse. A negedge monitor records what the DUT actually produces.
// Honours ST7735_RX_PARAM_CHECK_EN in the same way as the design.

module tb_st7735_spi_receiver;
  localparam int SYNC = 2;

  logic       SYSTEM_CLK = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       CS         = 1'b1;
  logic       LCD_CLK    = 1'b1;
  logic       MOSI       = 1'b0;
  logic       DC         = 1'b0;
  logic [7:0] BYTE_DATA;
  logic       BYTE_VALID;
  logic       BYTE_IS_CMD;
  logic [7:0] CMD_REG;
  logic [4:0] PARAM_INDEX;
  logic       BUSY;
  logic       FRAME_ERR;
  logic       PARAM_ERR;

  st7735_spi_receiver #(.SYNC_STAGES(SYNC), .PARAM_MAX(31)) dut (
    .SYSTEM_CLK (SYSTEM_CLK),
    .RESET_N    (RESET_N),
    .CS         (CS),
    .LCD_CLK    (LCD_CLK),
    .MOSI       (MOSI),
    .DC         (DC),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_IS_CMD(BYTE_IS_CMD),
    .CMD_REG    (CMD_REG),
    .PARAM_INDEX(PARAM_INDEX),
    .BUSY       (BUSY),
    .FRAME_ERR  (FRAME_ERR),
    .PARAM_ERR  (PARAM_ERR)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  typedef struct {
    logic [7:0] data;
    logic       is_cmd;
    logic [7:0] cmd;
    logic [4:0] pidx;
    logic       perr;
    int         cyc;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fe_cnt   = 0;
  int   fe_mark  = 0;
  int   obs_rd   = 0;
  int   exp_rd   = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];

  logic [7:0] wb[$];
  logic       wd[$];

  logic [7:0] m_cmd;
  int         m_pidx;
  logic       m_perr;

  // Count rising edges of the system clock
  always @(posedge SYSTEM_CLK) cyc <= cyc + 1;

  // Monitor: record every completed byte and count FRAME_ERR cycles
  always @(negedge SYSTEM_CLK) begin : mon
    rec_t r;
    if (BYTE_VALID === 1'b1) begin
      r.data   = BYTE_DATA;
      r.is_cmd = BYTE_IS_CMD;
      r.cmd    = CMD_REG;
      r.pidx   = PARAM_INDEX;
      r.perr   = PARAM_ERR;
      r.cyc    = cyc;
      obs_q.push_back(r);
    end
    if (FRAME_ERR === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef ST7735_RX_PARAM_CHECK_EN
  function automatic int param_limit(input logic [7:0] c);
    case (c)
      8'h11: return 0;
      8'hB1, 8'hB2, 8'hC0: return 3;
      8'hB3: return 6;
      8'hB4, 8'hC1, 8'hC5: return 1;
      8'hC2, 8'hC3, 8'hC4: return 2;
      8'hE0, 8'hE1: return 16;
      default: return -1;
    endcase
  endfunction
`endif

  task automatic model_reset();
    m_cmd  = 8'h00;
    m_pidx = 0;
    m_perr = 1'b0;
  endtask

  // Predict the outputs seen with one completed byte
  task automatic model_byte(input logic [7:0] b, input logic dc, input int at_cyc);
    rec_t r;
    if (!dc) begin
      m_cmd  = b;
      m_pidx = 0;
    end else begin
      if (m_pidx < 31) m_pidx++;
`ifdef ST7735_RX_PARAM_CHECK_EN
      if (param_limit(m_cmd) >= 0 && m_pidx > param_limit(m_cmd)) m_perr = 1'b1;
`endif
    end
    r.data   = b;
    r.is_cmd = ~dc;
    r.cmd    = m_cmd;
    r.pidx   = 5'(m_pidx);
    r.perr   = m_perr;
    r.cyc    = at_cyc;
    exp_q.push_back(r);
  endtask

  // Shift n bits MSB first with LCD_CLK at SYSTEM_CLK/4
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc,
                           input bit last_cs, input bit counted);
    for (int i = 0; i < n; i++) begin
      @(negedge SYSTEM_CLK);
      LCD_CLK = 1'b0;
      MOSI    = b[7-i];
      DC      = dc;
      repeat (2) @(negedge SYSTEM_CLK);
      LCD_CLK = 1'b1;
      if (i == 7 && counted) model_byte(b, dc, cyc + SYNC + 1);
      if (i == n - 1 && last_cs) CS = 1'b1;
      @(negedge SYSTEM_CLK);
    end
  endtask

  // Send the queued bytes inside one CS window
  task automatic run_window();
    @(negedge SYSTEM_CLK);
    CS = 1'b0;
    repeat (4) @(negedge SYSTEM_CLK);
    foreach (wb[i]) send_bits(wb[i], 8, wd[i], 1'b0, 1'b1);
    repeat (4) @(negedge SYSTEM_CLK);
    CS = 1'b1;
    repeat (6) @(negedge SYSTEM_CLK);
    wb.delete();
    wd.delete();
  endtask

  // Compare the bytes received since the last call with the predictions
  task automatic verify(input string tag, input int fe_exp);
    check({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size() - exp_rd);
    while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
      check($sformatf("%s_data%0d", tag, exp_rd), obs_q[obs_rd].data, exp_q[exp_rd].data);
      check($sformatf("%s_iscmd%0d", tag, exp_rd), obs_q[obs_rd].is_cmd, exp_q[exp_rd].is_cmd);
      check($sformatf("%s_cmdreg%0d", tag, exp_rd), obs_q[obs_rd].cmd, exp_q[exp_rd].cmd);
      check($sformatf("%s_pidx%0d", tag, exp_rd), obs_q[obs_rd].pidx, exp_q[exp_rd].pidx);
      check($sformatf("%s_perr%0d", tag, exp_rd), obs_q[obs_rd].perr, exp_q[exp_rd].perr);
      check($sformatf("%s_cycle%0d", tag, exp_rd), obs_q[obs_rd].cyc, exp_q[exp_rd].cyc);
      obs_rd++;
      exp_rd++;
    end
    obs_rd = obs_q.size();
    exp_rd = exp_q.size();
    check({tag, "_frame_err"}, fe_cnt - fe_mark, fe_exp);
    fe_mark = fe_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_data"}, BYTE_DATA, 8'h00);
    check({tag, "_byte_valid"}, BYTE_VALID, 1'b0);
    check({tag, "_byte_is_cmd"}, BYTE_IS_CMD, 1'b0);
    check({tag, "_cmd_reg"}, CMD_REG, 8'h00);
    check({tag, "_param_index"}, PARAM_INDEX, 5'd0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_frame_err"}, FRAME_ERR, 1'b0);
    check({tag, "_param_err"}, PARAM_ERR, 1'b0);
  endtask

  logic [7:0] cmds [10] = '{8'h11, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hE0, 8'h2C, 8'h3A, 8'h36};

  initial begin
    model_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge SYSTEM_CLK);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSTEM_CLK);

    // Single command byte
    wb.push_back(8'h11); wd.push_back(1'b0);
    run_window();
    verify("cmd11", 0);
    check("cmd11_cmd_reg_level", CMD_REG, 8'h11);
    check("cmd11_pidx_level", PARAM_INDEX, 5'd0);
    check("cmd11_is_cmd_level", BYTE_IS_CMD, 1'b1);

    // Command plus three back-to-back parameters
    wb = '{8'hB1, 8'h01, 8'h2C, 8'h2D};
    wd = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_window();
    verify("b1_params", 0);
    check("b1_cmd_reg_level", CMD_REG, 8'hB1);
    check("b1_pidx_level", PARAM_INDEX, 5'd3);

    // Five bits, then CS release: frame error, no byte
    @(negedge SYSTEM_CLK);
    CS = 1'b0;
    repeat (4) @(negedge SYSTEM_CLK);
    send_bits(8'hA5, 5, 1'b1, 1'b0, 1'b0);
    check("partial_busy", BUSY, 1'b1);
    CS = 1'b1;
    repeat (6) @(negedge SYSTEM_CLK);
    verify("partial", 1);
    check("partial_busy_after", BUSY, 1'b0);
    wb.push_back(8'hC0); wd.push_back(1'b0);
    run_window();
    verify("after_partial", 0);

    // CS release in the same cycle as the 8th clock edge
    @(negedge SYSTEM_CLK);
    CS = 1'b0;
    repeat (4) @(negedge SYSTEM_CLK);
    send_bits(8'h5A, 8, 1'b1, 1'b1, 1'b1);
    repeat (8) @(negedge SYSTEM_CLK);
    verify("cs_on_last_edge", 0);

    // LCD_CLK activity with CS high is ignored
    send_bits(8'hFF, 8, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge SYSTEM_CLK);
    verify("cs_high_ignored", 0);

    // Parameter overrun on a command expecting a single parameter
    wb = '{8'hC1, 8'h05, 8'h06};
    wd = '{1'b0, 1'b1, 1'b1};
    run_window();
    verify("c1_overrun", 0);
    check("c1_param_err_level", PARAM_ERR, m_perr);

    // PARAM_INDEX saturation on an unchecked command
    wb.push_back(8'h2C); wd.push_back(1'b0);
    for (int k = 0; k < 33; k++) begin
      wb.push_back(8'(k * 7 + 3));
      wd.push_back(1'b1);
    end
    run_window();
    verify("saturate", 0);
    check("saturate_pidx_level", PARAM_INDEX, 5'd31);

    // Random windows
    for (int w = 0; w < 6; w++) begin
      int nb;
      nb = $urandom_range(1, 6);
      wb.push_back(cmds[$urandom_range(0, 9)]);
      wd.push_back(1'b0);
      for (int k = 0; k < nb; k++) begin
        wb.push_back(8'($urandom));
        wd.push_back(($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1);
      end
      run_window();
      verify($sformatf("rand%0d", w), 0);
      check($sformatf("rand%0d_param_err_level", w), PARAM_ERR, m_perr);
    end

    // Reset in the middle of a byte
    @(negedge SYSTEM_CLK);
    CS = 1'b0;
    repeat (4) @(negedge SYSTEM_CLK);
    send_bits(8'hF0, 4, 1'b0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    CS      = 1'b1;
    repeat (3) @(negedge SYSTEM_CLK);
    RESET_N = 1'b1;
    model_reset();
    @(negedge SYSTEM_CLK);
    check_reset_outputs("mid_reset");
    repeat (4) @(negedge SYSTEM_CLK);
    verify("mid_reset", 0);
    wb.push_back(8'h3A); wd.push_back(1'b0);
    run_window();
    verify("after_reset", 0);
    check("after_reset_byte_data", BYTE_DATA, 8'h3A);

    check("total_bytes", obs_q.size(), exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
